// File: rtl/mm_pkg.sv
// Shared types and array geometry for the eight_x_eight host-side sequencer.
package mm_pkg;
    localparam int N              = 8;
    localparam int COMPUTE_CYCLES = 8;
    localparam int DRAIN_CYCLES   = 15;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int ROW_W = $clog2(N);
    // One phase counter serves LOAD, COMPUTE and DRAIN, so it is sized for the longest phase.
    localparam int CNT_W = $clog2(max3(N, COMPUTE_CYCLES, DRAIN_CYCLES)) + 1;
    localparam int RD_W  = $clog2(N) + 1;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        COMPUTE,
        DRAIN,
        READ
    } state_t;
endpackage

// File: rtl/mm_skid_fifo.sv
// Two-entry result FIFO between the array output buffer and the m_* stream.
module mm_skid_fifo #(
    parameter int W = 256
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mm8_sequencer.sv
// Host-side initiator: collects one A/B job, steps the systolic array through
// clear/load/compute/drain/read and streams the N result rows with backpressure.
module mm8_sequencer
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    input  logic signed [DATA_WIDTH-1:0] i_s_a [N],
    input  logic signed [DATA_WIDTH-1:0] i_s_b [N],
    output logic                         o_array_clr,
    output logic                         o_input_write,
    output logic [ROW_W-1:0]             o_row_ptr,
    output logic signed [DATA_WIDTH-1:0] o_a_in [N],
    output logic signed [DATA_WIDTH-1:0] o_b_in [N],
    output logic                         o_enable,
    output logic                         o_output_write,
    output logic                         o_output_read,
    input  logic signed [ACC_WIDTH-1:0]  i_c_out [N],
    output logic                         o_m_valid,
    input  logic                         i_m_ready,
    output logic signed [ACC_WIDTH-1:0]  o_m_c [N],
    output logic [ROW_W-1:0]             o_m_row,
    output logic                         o_m_last,
    output logic                         o_busy
);
    state_t                       r_state;
    state_t                       w_state_next;
    logic [CNT_W-1:0]             r_cnt;
    logic [RD_W-1:0]              r_rd_cnt;
    logic [RD_W-1:0]              r_out_cnt;
    logic                         r_input_write;
    logic                         r_rd_pend;
    row_t                         r_row_ptr;
    logic signed [DATA_WIDTH-1:0] r_a_in [N];
    logic signed [DATA_WIDTH-1:0] r_b_in [N];
    logic                         w_beat;
    logic                         w_pop;
    logic                         w_cnt_step;
    logic [1:0]                   w_fifo_count;
    logic [N*ACC_WIDTH-1:0]       w_c_flat;
    logic [N*ACC_WIDTH-1:0]       w_m_flat;

    assign w_beat = o_s_ready && i_s_valid;
    assign w_pop  = o_m_valid && i_m_ready;

    always_comb begin
        w_state_next   = r_state;
        o_s_ready      = 1'b0;
        o_array_clr    = 1'b0;
        o_enable       = 1'b0;
        o_output_write = 1'b0;
        o_output_read  = 1'b0;
        w_cnt_step     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_s_valid) w_state_next = CLEAR;
            end
            CLEAR: begin
                o_array_clr  = 1'b1;
                w_state_next = LOAD;
            end
            LOAD: begin
                o_s_ready  = 1'b1;
                w_cnt_step = i_s_valid;
                if (i_s_valid && r_cnt == CNT_W'(N - 1)) w_state_next = COMPUTE;
            end
            COMPUTE: begin
                // The last beat's input_write lands in the first COMPUTE cycle; hold enable off until it is done.
                o_enable   = !r_input_write;
                w_cnt_step = !r_input_write;
                if (w_cnt_step && r_cnt == CNT_W'(COMPUTE_CYCLES - 1)) w_state_next = DRAIN;
            end
            DRAIN: begin
                o_enable       = 1'b1;
                o_output_write = 1'b1;
                w_cnt_step     = 1'b1;
                if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) w_state_next = READ;
            end
            READ: begin
                // Rows already buffered plus the one still coming back from the array must fit in the FIFO.
                o_output_read = (r_rd_cnt != RD_W'(N)) &&
                                (({1'b0, w_fifo_count} + {2'b00, r_rd_pend}) < 3'd2);
                if (w_pop && r_out_cnt == RD_W'(N - 1)) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_rd_cnt      <= '0;
            r_out_cnt     <= '0;
            r_input_write <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_row_ptr     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_input_write <= w_beat;
            r_rd_pend     <= o_output_read;
            if (w_beat) r_row_ptr <= r_cnt[ROW_W-1:0];
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state != READ) begin
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (o_output_read) r_rd_cnt <= r_rd_cnt + RD_W'(1);
                if (w_pop) r_out_cnt <= r_out_cnt + RD_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_beat) begin
            r_a_in <= i_s_a;
            r_b_in <= i_s_b;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_pack
        assign w_c_flat[j*ACC_WIDTH +: ACC_WIDTH] = i_c_out[j];
        assign o_m_c[j] = w_m_flat[j*ACC_WIDTH +: ACC_WIDTH];
    end

    mm_skid_fifo #(
        .W(N * ACC_WIDTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (r_rd_pend),
        .i_push_data(w_c_flat),
        .o_valid    (o_m_valid),
        .i_ready    (i_m_ready),
        .o_data     (w_m_flat),
        .o_count    (w_fifo_count)
    );

    assign o_input_write = r_input_write;
    assign o_row_ptr     = r_row_ptr;
    assign o_a_in        = r_a_in;
    assign o_b_in        = r_b_in;
    assign o_m_row       = r_out_cnt[ROW_W-1:0];
    assign o_m_last      = o_m_valid && (r_out_cnt == RD_W'(N - 1));
    assign o_busy        = (r_state != IDLE);
endmodule

// File: tb/tb_mm8_sequencer.sv
// Scoreboard bench for mm8_sequencer with a behavioural model of the systolic array.
module tb_mm8_sequencer;
    import mm_pkg::*;

    localparam int DW = 8;
    localparam int AW = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_a [N];
    logic signed [DW-1:0] s_b [N];
    logic                 array_clr, input_write, enable, output_write, output_read;
    logic [ROW_W-1:0]     row_ptr;
    logic signed [DW-1:0] a_in [N];
    logic signed [DW-1:0] b_in [N];
    logic signed [AW-1:0] c_out [N];
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic signed [AW-1:0] m_c [N];
    logic [ROW_W-1:0]     m_row;
    logic                 m_last, busy;

    always #5 clk = ~clk;

    mm8_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(s_ready),
        .i_s_a(s_a), .i_s_b(s_b), .o_array_clr(array_clr), .o_input_write(input_write),
        .o_row_ptr(row_ptr), .o_a_in(a_in), .o_b_in(b_in), .o_enable(enable),
        .o_output_write(output_write), .o_output_read(output_read), .i_c_out(c_out),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_c(m_c), .o_m_row(m_row),
        .o_m_last(m_last), .o_busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // job matrices and expected result stream
    int     ja [N][N];
    int     jb [N][N];
    int     exp_row_q [$];
    longint exp_val_q [$];

    // stimulus knobs
    bit stall_arm = 0;
    int stall_cnt = 0;
    bit bp_mode   = 0;

    // array model and protocol bookkeeping
    int     bufa [N][N];
    int     bufb [N][N];
    longint acc  [N][N];
    longint pend_row [N];
    bit     pend_go = 0;
    int     rd_ptr = 0;
    bit     computed = 0;
    bit     job_open = 0;
    int     en_only = 0, en_ow = 0, iw_cnt = 0, rd_cnt = 0, hs_cnt = 0, viol = 0;
    bit     prev_stall = 0;
    int     prev_row = 0;
    longint prev_c [N];

    task automatic reset_job_stats();
        en_only = 0; en_ow = 0; iw_cnt = 0; rd_cnt = 0; hs_cnt = 0; viol = 0;
    endtask

    initial begin
        for (int c = 0; c < N; c++) c_out[c] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_go) begin
                for (int c = 0; c < N; c++) c_out[c] = AW'(pend_row[c]);
                pend_go = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (stall_arm && m_valid) begin
                stall_cnt = 20;
                stall_arm = 0;
            end
            if (stall_cnt > 0) begin
                m_ready = 1'b0;
                stall_cnt--;
            end else begin
                m_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin : observer
        int     nstb;
        int     r;
        longint e;
        int     bad;
        longint bad_act, bad_exp;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                job_open = 0; rd_ptr = 0; computed = 0; pend_go = 0; prev_stall = 0;
                reset_job_stats();
                for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
                continue;
            end
            if (prev_stall) begin
                bad = 0;
                for (int c = 0; c < N; c++) if (longint'(m_c[c]) != prev_c[c]) bad++;
                chk(m_valid && bad == 0 && int'(m_row) == prev_row, "hold_under_stall", bad, 0);
            end
            nstb = int'(array_clr) + int'(input_write) + int'(output_read) + int'(enable || output_write);
            if (nstb > 1 || (output_write && !enable)) viol++;
            if (array_clr) begin
                chk(!job_open, "clear_while_job_open", job_open, 0);
                job_open = 1; rd_ptr = 0; computed = 0;
                reset_job_stats();
                for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
            end
            if (input_write) begin
                if (en_only != 0 || en_ow != 0 || rd_cnt != 0) viol++;
                if (int'(row_ptr) != iw_cnt) viol++;
                for (int j = 0; j < N; j++) begin
                    bufa[j][row_ptr] = int'(a_in[j]);
                    bufb[j][row_ptr] = int'(b_in[j]);
                end
                iw_cnt++;
            end
            if (enable && !output_write) begin
                if (en_ow != 0 || rd_cnt != 0) viol++;
                en_only++;
            end
            if (enable && output_write) begin
                if (!computed) begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            for (int k = 0; k < N; k++)
                                acc[i][j] += longint'(bufa[i][k]) * longint'(bufb[k][j]);
                    computed = 1;
                end
                if (rd_cnt != 0) viol++;
                en_ow++;
            end
            if (output_read) begin
                if (rd_cnt == 0) begin
                    chk(iw_cnt == N, "input_write_count", iw_cnt, N);
                    chk(en_only == COMPUTE_CYCLES, "compute_cycles", en_only, COMPUTE_CYCLES);
                    chk(en_ow == DRAIN_CYCLES, "drain_cycles", en_ow, DRAIN_CYCLES);
                end
                for (int c = 0; c < N; c++) pend_row[c] = (rd_ptr < N) ? acc[rd_ptr][c] : 64'hDEAD;
                rd_ptr++;
                pend_go = 1;
                rd_cnt++;
            end
            if (rd_cnt - hs_cnt > 2) viol++;
            if (m_valid && m_ready) begin
                if (exp_row_q.size() == 0) begin
                    chk(0, "unexpected_row", m_row, -1);
                end else begin
                    r = exp_row_q.pop_front();
                    bad = 0; bad_act = 0; bad_exp = 0;
                    for (int c = 0; c < N; c++) begin
                        e = exp_val_q.pop_front();
                        if (longint'(m_c[c]) != e && bad == 0) begin
                            bad = 1; bad_act = m_c[c]; bad_exp = e;
                        end
                    end
                    chk(bad == 0, "m_c", bad_act, bad_exp);
                    chk(int'(m_row) == r, "m_row", m_row, r);
                    chk(m_last == (r == N - 1), "m_last", m_last, (r == N - 1));
                end
                hs_cnt++;
                if (m_last) begin
                    chk(rd_cnt == N, "output_read_count", rd_cnt, N);
                    chk(viol == 0, "protocol_violations", viol, 0);
                    job_open = 0;
                    reset_job_stats();
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_row   = int'(m_row);
            for (int c = 0; c < N; c++) prev_c[c] = longint'(m_c[c]);
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++; n_err++;
            $display("FAIL beat_accept_timeout: s_ready %0d after %0d cycles", s_ready, t);
        end
        @(negedge clk);
    endtask

    task automatic run_job(input bit toggle, input bit hold);
        longint sum;
        for (int r = 0; r < N; r++) begin
            exp_row_q.push_back(r);
            for (int c = 0; c < N; c++) begin
                sum = 0;
                for (int k = 0; k < N; k++) sum += longint'(ja[r][k]) * longint'(jb[k][c]);
                exp_val_q.push_back(sum);
            end
        end
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                s_a[j] = DW'(ja[j][k]);
                s_b[j] = DW'(jb[j][k]);
            end
            s_valid = 1'b1;
            wait_ready();
            if (toggle && k != N - 1) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((busy || exp_row_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++; n_err++;
            $display("FAIL job_timeout: %0d rows still outstanding", exp_row_q.size());
            exp_row_q.delete();
            exp_val_q.delete();
        end
    endtask

    task automatic check_reset(input string tag);
        chk(s_ready == 0,      {tag, "_s_ready"}, s_ready, 0);
        chk(m_valid == 0,      {tag, "_m_valid"}, m_valid, 0);
        chk(busy == 0,         {tag, "_busy"}, busy, 0);
        chk(array_clr == 0,    {tag, "_array_clr"}, array_clr, 0);
        chk(input_write == 0,  {tag, "_input_write"}, input_write, 0);
        chk(enable == 0,       {tag, "_enable"}, enable, 0);
        chk(output_write == 0, {tag, "_output_write"}, output_write, 0);
        chk(output_read == 0,  {tag, "_output_read"}, output_read, 0);
        chk(row_ptr == 0,      {tag, "_row_ptr"}, row_ptr, 0);
        chk(m_row == 0,        {tag, "_m_row"}, m_row, 0);
        chk(m_last == 0,       {tag, "_m_last"}, m_last, 0);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ja[i][j] = int'($urandom_range(0, 255)) - 128;
                jb[i][j] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ja[i][j] = av;
                jb[i][j] = bv;
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int cnt;
        for (int j = 0; j < N; j++) begin
            s_a[j] = '0;
            s_b[j] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // identity A, ramp B
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ja[i][j] = (i == j) ? 1 : 0;
                jb[i][j] = i * 8 + j;
            end
        run_job(0, 0);
        wait_done();

        // extreme operands
        fill_const(127, 127);
        run_job(0, 0);
        wait_done();
        fill_const(-128, 127);
        run_job(0, 0);
        wait_done();

        // s_valid toggling 1-0-1
        fill_rand();
        run_job(1, 0);
        wait_done();

        // 20-cycle stall after first m_valid
        fill_rand();
        stall_arm = 1;
        run_job(0, 0);
        wait_done();

        // random jobs under random backpressure
        bp_mode = 1;
        for (int n = 0; n < 4; n++) begin
            fill_rand();
            run_job(n[0], 0);
            wait_done();
        end
        bp_mode = 0;

        // reset in DRAIN cycle 5, then a clean job
        fill_rand();
        run_job(0, 0);
        t = 0;
        cnt = 0;
        while (cnt < 5 && t < 1000) begin
            @(negedge clk);
            t++;
            if (output_write) cnt++;
        end
        if (t >= 1000) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: saw %0d drain cycles", cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("mid_job_rst");
        exp_row_q.delete();
        exp_val_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_rand();
        run_job(0, 0);
        wait_done();

        // back-to-back jobs with s_valid held high
        fill_rand();
        run_job(0, 1);
        fill_rand();
        run_job(0, 0);
        wait_done();

        repeat (5) @(negedge clk);
        chk(exp_row_q.size() == 0, "rows_outstanding", exp_row_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
